// File: rtl/uart_rx_stage_pkg.sv
// Shared definitions for the UART receive stage: FSM state encoding and
// oversampling constants.
package uart_rx_stage_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } state_t;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned START_MID  = 7;

endpackage

// File: rtl/baud_tick_gen.sv
// Free-running mod-DVSR divider producing the 16x oversample tick.
module baud_tick_gen #(
    parameter int DVSR   = 326,
    parameter int DVSR_W = 9
) (
    input  logic clk,
    input  logic reset,
    output logic s_tick
);

    localparam logic [DVSR_W-1:0] LAST = DVSR_W'(DVSR - 1);

    logic [DVSR_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign s_tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_rx_stage.sv
// 8N1 UART receiver: 2-flop input synchronizer, 16x oversampling FSM and
// registered byte/pulse outputs for direct connection to a byte FIFO.
module uart_rx_stage
    import uart_rx_stage_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int DVSR    = 326,
    parameter int DVSR_W  = 9
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            frame_err
);

    localparam int N_W = (DBIT > 1) ? $clog2(DBIT) : 1;

    logic [1:0]      sync_q;
    logic            rx_s;
    logic            s_tick;
    state_t          state_q, state_d;
    logic [3:0]      s_q, s_d;
    logic [N_W-1:0]  n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic [DBIT-1:0] dout_q, dout_d;
    logic            done_q, done_d;
    logic            ferr_q, ferr_d;

    baud_tick_gen #(
        .DVSR   (DVSR),
        .DVSR_W (DVSR_W)
    ) u_baud (
        .clk    (clk),
        .reset  (reset),
        .s_tick (s_tick)
    );

    assign rx_s = sync_q[1];

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Pulses are computed combinationally and registered, so dout and its
    // strobe leave the block on the same clock edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 2'b11;
            s_q    <= '0;
            n_q    <= '0;
            b_q    <= '0;
            dout_q <= '0;
            done_q <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], rx};
            s_q    <= s_d;
            n_q    <= n_d;
            b_q    <= b_d;
            dout_q <= dout_d;
            done_q <= done_d;
            ferr_q <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    s_d     = '0;
                    state_d = START;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_q == 4'(START_MID)) begin
                        if (!rx_s) begin
                            s_d     = '0;
                            n_d     = '0;
                            state_d = DATA;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_q == 4'(OVERSAMPLE - 1)) begin
                        s_d = '0;
                        b_d = {rx_s, b_q[DBIT-1:1]};
                        if (n_q == N_W'(DBIT - 1)) state_d = STOP;
                        else                       n_d = n_q + 1'b1;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_q == 4'(SB_TICK - 1)) begin
                        dout_d  = b_q;
                        done_d  = rx_s;
                        ferr_d  = !rx_s;
                        state_d = IDLE;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign dout         = dout_q;
    assign rx_done_tick = done_q;
    assign frame_err    = ferr_q;

endmodule
